// File: rtl/key_cmd_scheduler.sv
// Key command scheduler: turns debounced key presses and hold-to-repeat events into
// sticky pending commands and presents them one at a time on a valid/ready port.
module key_cmd_scheduler #(
    parameter int unsigned REPEAT_DELAY = 6720000,
    parameter int unsigned REPEAT_RATE  = 2100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] key_press,
    input  logic [3:0] key_held,
    output logic       cmd_valid,
    output logic [1:0] cmd_code,
    input  logic       cmd_ready
);
    // Handshake: a command transfers in any cycle where cmd_valid && cmd_ready; while
    // cmd_valid is high and cmd_ready is low, cmd_valid and cmd_code stay stable.

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_e;

    localparam logic [31:0] DELAY_LAST = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] RATE_LAST  = 32'(REPEAT_RATE - 1);

    // Element i of the repeat arrays serves key bit i+1 (left, right, down).
    rep_state_e  state_q [3];
    rep_state_e  state_d [3];
    logic [31:0] cnt_q   [3];
    logic [31:0] cnt_d   [3];
    logic [2:0]  force_idle;
    logic [2:0]  rep_ev;
    logic        lr_both;

    logic [3:0]  pend_q;
    logic [3:0]  pend_d;
    logic [3:0]  pend_clr;
    logic        load;
    logic        cmd_valid_q;
    logic        cmd_valid_d;
    logic [1:0]  cmd_code_q;
    logic [1:0]  cmd_code_d;

    always_comb begin
        lr_both = key_held[1] & key_held[2];
        for (int i = 0; i < 3; i++) begin
            state_d[i]    = state_q[i];
            cnt_d[i]      = cnt_q[i];
            rep_ev[i]     = 1'b0;
            force_idle[i] = !enable || !key_held[i+1] || ((i != 2) && lr_both);
            if (force_idle[i]) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (key_press[i+1]) begin
                            state_d[i] = ST_DELAY;
                            cnt_d[i]   = '0;
                        end
                    end
                    ST_DELAY: begin
                        if (cnt_q[i] == DELAY_LAST) begin
                            state_d[i] = ST_REPEAT;
                            cnt_d[i]   = '0;
                            rep_ev[i]  = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 32'd1;
                        end
                    end
                    ST_REPEAT: begin
                        if (cnt_q[i] == RATE_LAST) begin
                            cnt_d[i]  = '0;
                            rep_ev[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 32'd1;
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Output stage selects from the registered pending bits; new events land one cycle later.
    always_comb begin
        load        = enable && (!cmd_valid_q || cmd_ready);
        pend_clr    = 4'b0000;
        cmd_valid_d = cmd_valid_q;
        cmd_code_d  = cmd_code_q;
        if (load) begin
            cmd_valid_d = |pend_q;
            if (pend_q[0]) begin
                cmd_code_d = 2'd0;
                pend_clr   = 4'b0001;
            end else if (pend_q[1]) begin
                cmd_code_d = 2'd1;
                pend_clr   = 4'b0010;
            end else if (pend_q[2]) begin
                cmd_code_d = 2'd2;
                pend_clr   = 4'b0100;
            end else if (pend_q[3]) begin
                cmd_code_d = 2'd3;
                pend_clr   = 4'b1000;
            end
        end else if (!enable && cmd_ready) begin
            cmd_valid_d = 1'b0;
        end
        // Setting after clearing lets a same-cycle event survive the load.
        if (enable) begin
            pend_d = (pend_q & ~pend_clr) | key_press | {rep_ev, 1'b0};
        end else begin
            pend_d = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            pend_q      <= '0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= 2'd0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pend_q      <= pend_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Bench for key_cmd_scheduler: directed vector table, hand-written repeat/enable/reset
// sequences and a long random run against a hold-age reference model.
module tb_key_cmd_scheduler;
    localparam int RD   = 10;
    localparam int RR   = 4;
    localparam int HOLD = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] key_press;
    logic [3:0] key_held;
    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic       cmd_ready;

    always #5 clk = ~clk;

    key_cmd_scheduler #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .key_press (key_press),
        .key_held  (key_held),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_ready (cmd_ready)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: a repeat key is "armed" from the press cycle; it emits an event
    // whenever its hold age equals RD + m*RR while it stays held and enabled.
    bit         m_armed   [1:3];
    int         m_press_t [1:3];
    logic [3:0] m_pend  = 4'b0000;
    logic       m_valid = 1'b0;
    logic [1:0] m_code  = 2'd0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] press;
        logic [3:0] held;
        logic       rdy;
        logic       exp_v;
        logic [1:0] exp_c;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic void model_update();
        logic [3:0] ev;
        logic [3:0] clr;
        logic       lr;
        bit         force_idle;
        int         age;
        ev  = 4'b0000;
        clr = 4'b0000;
        if (rst) begin
            for (int k = 1; k <= 3; k++) m_armed[k] = 1'b0;
            m_pend  = 4'b0000;
            m_valid = 1'b0;
            m_code  = 2'd0;
            return;
        end
        lr = key_held[1] && key_held[2];
        for (int k = 1; k <= 3; k++) begin
            force_idle = !enable || !key_held[k] || (k < 3 && lr);
            if (force_idle) begin
                m_armed[k] = 1'b0;
            end else if (m_armed[k]) begin
                age = cyc - m_press_t[k];
                if (age >= RD && ((age - RD) % RR) == 0) ev[k] = 1'b1;
            end else if (key_press[k]) begin
                m_armed[k]   = 1'b1;
                m_press_t[k] = cyc;
            end
        end
        if (enable && (!m_valid || cmd_ready)) begin
            m_valid = 1'b0;
            for (int k = 3; k >= 0; k--) begin
                if (m_pend[k]) begin
                    m_valid = 1'b1;
                    m_code  = 2'(k);
                end
            end
            if (m_valid) clr[m_code] = 1'b1;
        end else if (!enable && m_valid && cmd_ready) begin
            m_valid = 1'b0;
        end
        if (enable) m_pend = (m_pend & ~clr) | key_press | ev;
        else        m_pend = 4'b0000;
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
        check("model_valid", 32'(cmd_valid), 32'(m_valid));
        if (m_valid) check("model_code", 32'(cmd_code), 32'(m_code));
    endtask

    task automatic drive(input logic r, input logic en, input logic [3:0] p,
                         input logic [3:0] h, input logic rdy);
        rst       = r;
        enable    = en;
        key_press = p;
        key_held  = h;
        cmd_ready = rdy;
        step();
    endtask

    task automatic add_vec(input logic r, input logic en, input logic [3:0] p,
                           input logic [3:0] h, input logic rdy,
                           input logic ev, input logic [1:0] ec);
        vec_t v;
        v.rst = r; v.en = en; v.press = p; v.held = h; v.rdy = rdy;
        v.exp_v = ev; v.exp_c = ec;
        tbl.push_back(v);
    endtask

    initial begin
        vec_t       v;
        int         c0;
        int         n;
        int         nmin;
        logic [3:0] p;
        logic [3:0] h;
        logic       en_r;

        rst = 1'b1; enable = 1'b1; key_press = 4'b0; key_held = 4'b0; cmd_ready = 1'b0;

        // Reset, three-key priority burst, stalled rotate with a second press, single left
        // press latency, and a press landing on the cycle its pending bit is consumed.
        add_vec(1, 1, 4'b0000, 4'b0000, 0, 0, 2'd0);
        add_vec(0, 1, 4'b0000, 4'b0000, 1, 0, 2'd0);
        add_vec(0, 1, 4'b1011, 4'b0000, 1, 0, 2'd0);
        add_vec(0, 1, 4'b0000, 4'b0000, 1, 1, 2'd0);
        add_vec(0, 1, 4'b0000, 4'b0000, 1, 1, 2'd1);
        add_vec(0, 1, 4'b0000, 4'b0000, 1, 1, 2'd3);
        add_vec(0, 1, 4'b0000, 4'b0000, 1, 0, 2'd0);
        add_vec(0, 1, 4'b0001, 4'b0000, 0, 0, 2'd0);
        add_vec(0, 1, 4'b0000, 4'b0000, 0, 1, 2'd0);
        add_vec(0, 1, 4'b0001, 4'b0000, 0, 1, 2'd0);
        for (int i = 0; i < 5; i++) add_vec(0, 1, 4'b0000, 4'b0000, 0, 1, 2'd0);
        add_vec(0, 1, 4'b0000, 4'b0000, 1, 1, 2'd0);
        add_vec(0, 1, 4'b0000, 4'b0000, 1, 0, 2'd0);
        add_vec(0, 1, 4'b0000, 4'b0000, 1, 0, 2'd0);
        add_vec(0, 1, 4'b0010, 4'b0000, 1, 0, 2'd0);
        add_vec(0, 1, 4'b0000, 4'b0000, 1, 1, 2'd1);
        add_vec(0, 1, 4'b0000, 4'b0000, 1, 0, 2'd0);
        add_vec(0, 1, 4'b0001, 4'b0000, 1, 0, 2'd0);
        add_vec(0, 1, 4'b0001, 4'b0000, 1, 1, 2'd0);
        add_vec(0, 1, 4'b0000, 4'b0000, 1, 1, 2'd0);
        add_vec(0, 1, 4'b0000, 4'b0000, 1, 0, 2'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            drive(v.rst, v.en, v.press, v.held, v.rdy);
            check($sformatf("tbl%0d_valid", i), 32'(cmd_valid), 32'(v.exp_v));
            if (v.exp_v) check($sformatf("tbl%0d_code", i), 32'(cmd_code), 32'(v.exp_c));
            if (v.rst) check("reset_code", 32'(cmd_code), 32'd0);
        end

        // Hold right for HOLD cycles: initial command plus repeats at hold ages RD + m*RR.
        exp_q.push_back({14'd2, 2'd2});
        for (int a = RD; a < HOLD; a += RR) exp_q.push_back({14'(a + 2), 2'd2});
        c0 = cyc;
        for (int i = 0; i < HOLD + 10; i++) begin
            drive(0, 1, (i == 0) ? 4'b0100 : 4'b0000, (i < HOLD) ? 4'b0100 : 4'b0000, 1);
            if (cmd_valid) got_q.push_back({14'(cyc - c0), cmd_code});
        end
        check("rpt_count", 32'(got_q.size()), 32'(exp_q.size()));
        nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) check($sformatf("rpt_cmd%0d", i), 32'(got_q[i]), 32'(exp_q[i]));

        // Hold left into repeat, drop enable, then re-enable while still held.
        n = 0;
        drive(0, 1, 4'b0010, 4'b0010, 1);
        for (int i = 0; i < RD + RR + 2; i++) begin
            drive(0, 1, 4'b0000, 4'b0010, 1);
            if (cmd_valid) n++;
        end
        check("left_repeats_seen", 32'(n >= 2), 32'd1);
        for (int i = 0; i < 5; i++) drive(0, 0, 4'b0000, 4'b0010, 1);
        n = 0;
        for (int i = 0; i < RD + 3 * RR; i++) begin
            drive(0, 1, 4'b0000, 4'b0010, 1);
            if (cmd_valid) n++;
        end
        check("no_repeat_after_enable", 32'(n), 32'd0);
        for (int i = 0; i < 3; i++) drive(0, 1, 4'b0000, 4'b0000, 1);

        // Reset while a down command is stalled and its repeat delay is running.
        drive(0, 1, 4'b1000, 4'b1000, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 4'b0000, 4'b1000, 0);
        check("pre_reset_valid", 32'(cmd_valid), 32'd1);
        drive(1, 1, 4'b0000, 4'b1000, 0);
        check("reset_drops_valid", 32'(cmd_valid), 32'd0);
        n = 0;
        for (int i = 0; i < RD + 3 * RR; i++) begin
            drive(0, 1, 4'b0000, 4'b1000, 1);
            if (cmd_valid) n++;
        end
        check("no_repeat_after_reset", 32'(n), 32'd0);

        // Random run: keys rise with a press pulse and release at random, occasional
        // stray pulses, ready back-pressure, enable toggles and rare resets.
        en_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            p = 4'b0000;
            h = key_held;
            for (int k = 0; k < 4; k++) begin
                if (h[k]) begin
                    if ($urandom_range(0, 24) == 0) h[k] = 1'b0;
                end else if ($urandom_range(0, 11) == 0) begin
                    h[k] = 1'b1;
                    p[k] = 1'b1;
                end else if ($urandom_range(0, 39) == 0) begin
                    p[k] = 1'b1;
                end
            end
            if ($urandom_range(0, 149) == 0) en_r = ~en_r;
            drive(($urandom_range(0, 299) == 0), en_r, p, h, ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_cmd_scheduler.md
KEY_CMD_SCHEDULER -- requirements
Module: key_cmd_scheduler

Interface
REQ-001 The block SHALL have parameter REPEAT_DELAY, default 6720000, meaning the hold cycles before auto-repeat starts (16 frames of 800*525).
REQ-002 The block SHALL have parameter REPEAT_RATE, default 2100000, meaning the cycles between auto-repeats (5 frames).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port enable, input, 1 bit: high means the game is running and commands are accepted; low means paused.
REQ-006 The block SHALL have port key_press, input, 4 bits: one-cycle pulses from the key debouncers; bit0 rotate, bit1 left, bit2 right, bit3 down.
REQ-007 The block SHALL have port key_held, input, 4 bits: debounced held levels, with the same bit order as key_press.
REQ-008 The block SHALL have port cmd_valid, output, 1 bit: a command is presented.
REQ-009 The block SHALL have port cmd_code, output, 2 bits: the command; 0 rotate, 1 left, 2 right, 3 down.
REQ-010 The block SHALL have port cmd_ready, input, 1 bit: the game logic accepts the command this cycle.

Function
REQ-011 The block SHALL keep one sticky pending bit per command.
REQ-012 A set pending bit SHALL be set by a key_press pulse or by an auto-repeat event for that command.
REQ-013 Repeated events for an already-pending command SHALL collapse into one command.
REQ-014 Left, right and down SHALL each have a repeat FSM with states IDLE, DELAY and REPEAT, plus a 32-bit counter.
REQ-015 In IDLE, a key_press pulse on the key SHALL move the FSM to DELAY with counter=0.
REQ-016 In DELAY, the counter SHALL increment each cycle; when counter reaches REPEAT_DELAY-1, the FSM SHALL move to REPEAT, set the pending bit, and clear the counter.
REQ-017 In REPEAT, the counter SHALL increment each cycle; when counter reaches REPEAT_RATE-1, the FSM SHALL set the pending bit and clear the counter.
REQ-018 If key_held is low in any state, the FSM SHALL go to IDLE with counter=0 and SHALL generate no repeat event that cycle.
REQ-019 Rotate SHALL have no repeat FSM; only key_press sets its pending bit.
REQ-020 Left and right held simultaneously SHALL force both of their FSMs to IDLE; their press pulses still set pending bits.
REQ-021 The output stage SHALL load when cmd_valid==0, or when cmd_valid==1 and cmd_ready==1.
REQ-022 On load, the output stage SHALL select the highest-priority pending bit (rotate > left > right > down), register it to cmd_code, set cmd_valid, and clear that pending bit.
REQ-023 If nothing is pending on load, the output stage SHALL drive cmd_valid=0.
REQ-024 While cmd_valid==1 and cmd_ready==0, cmd_valid and cmd_code SHALL hold stable.
REQ-025 Latency SHALL be as follows: a key_press pulse in cycle N with the output stage free gives cmd_valid=1 with that code in cycle N+2.
REQ-026 Back-to-back acceptance with cmd_ready held high SHALL sustain one command per cycle.
REQ-027 If a new event for a command arrives in the same cycle its pending bit is cleared by a load, the bit SHALL remain set; set wins.
REQ-028 When enable==0, all pending bits SHALL be cleared and all FSMs SHALL be forced to IDLE.
REQ-029 When enable==0, key inputs SHALL be ignored and no new command SHALL load.
REQ-030 A command already presented when enable drops SHALL stay valid until accepted.
REQ-031 Counters SHALL never wrap, because they are cleared at the thresholds above.

Reset
REQ-032 When rst==1 at a clock edge, the block SHALL drive cmd_valid=0, cmd_code=0, clear all pending bits, set all FSMs to IDLE, and set all counters to 0; these values take effect on the next cycle.
REQ-033 Reset SHALL take priority over enable and all key inputs, and SHALL discard any in-flight command, including mid-delay or mid-repeat.
REQ-034 The first command after reset deasserts SHALL require a fresh key_press pulse.

Verification (REPEAT_DELAY=10, REPEAT_RATE=4, enable=1 unless stated)
REQ-035 Scenario: pulse key_press[1] at cycle 5 with cmd_ready=1 -> cmd_valid=1, cmd_code=1 at cycle 7 only.
REQ-036 Scenario: pulse key_press[2] at cycle 0 and hold key_held[2] for 30 cycles, with cmd_ready=1 -> commands of code 2 from the initial pulse and then the repeat events at 10 and 4 intervals per REQ-016/017; exact cycle numbers to be computed from REQ-016/017 and REQ-025, not estimated; no commands after release.
REQ-037 Scenario: pulse bits 0,1,3 in the same cycle with cmd_ready=1 -> codes 0, 1, 3 on three consecutive cycles.
REQ-038 Scenario: cmd_ready=0 for 8 cycles after a rotate press, plus a second rotate press during the stall -> code 0 held stable; after ready, exactly one more rotate command is issued.
REQ-039 Scenario: hold left, drop enable during REPEAT -> no further commands and the FSM is IDLE; after enable returns with left still held, there is no repeat without a new press.
REQ-040 Scenario: assert rst while cmd_valid==1 and an FSM is in DELAY -> cmd_valid=0 next cycle and no later repeat command.
